// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
package multdiv_issue_ctrl_pkg;

  // Sequencer states; encodings are visible on debug taps, so keep them fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Exception codes returned to writeback.
  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_DIV0    = 2'b01;
  localparam logic [1:0] EXC_RANGE   = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  localparam int DEFAULT_TIMEOUT = 40;
  localparam int DEFAULT_REG_W   = 5;

  // The divider only takes a 16-bit signed divisor: bits [31:15] must be a
  // pure sign extension for the value to be representable.
  function automatic logic fits_s16(input logic [31:0] value);
    return (value[31:15] == '0) || (value[31:15] == '1);
  endfunction

endpackage

// File: rtl/multdiv_wait_timer.sv
// Clearable up-counter that flags when the wait budget has been used up.
module multdiv_wait_timer
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Count wait cycles; hold at the terminal value so the count never wraps.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_terminal = (r_count == TERM_COUNT);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/sequencing front-end for the mult/div unit: accepts one op, fires a
// one-cycle start pulse, waits for ready or timeout and hands the result to
// writeback while holding the pipeline stalled.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int REG_W   = DEFAULT_REG_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             ex_is_div,
  input  logic [31:0]      ex_opA,
  input  logic [31:0]      ex_opB,
  input  logic [REG_W-1:0] ex_rd,
  output logic             stall,
  output logic [31:0]      md_opA,
  output logic [31:0]      md_opB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic             md_resultRDY,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [31:0]      wb_result,
  output logic [1:0]       wb_exc
);

  state_e           r_state;
  state_e           w_next_state;
  logic [REG_W-1:0] r_rd;

  logic             w_accept;
  logic             w_start_mult;
  logic             w_start_div;
  logic             w_wb_load;
  logic [REG_W-1:0] w_wb_rd;
  logic [31:0]      w_wb_result;
  logic [1:0]       w_wb_exc;
  logic             w_timer_clear;
  logic             w_timer_en;
  logic             w_timer_term;

  multdiv_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clear    (w_timer_clear),
    .i_enable   (w_timer_en),
    .o_terminal (w_timer_term)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus next values for the registered outputs.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_start_mult  = 1'b0;
    w_start_div   = 1'b0;
    w_wb_load     = 1'b0;
    w_wb_rd       = r_rd;
    w_wb_result   = '0;
    w_wb_exc      = EXC_NONE;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;

    case (r_state)
      IDLE: begin
        if (ex_valid) begin
          w_accept = 1'b1;
          if (ex_is_div && !fits_s16(ex_opB)) begin
            // Divisor not representable: report without touching the unit.
            w_next_state = DONE;
            w_wb_load    = 1'b1;
            w_wb_rd      = ex_rd;
            w_wb_exc     = EXC_RANGE;
          end else begin
            w_next_state = ISSUE;
            w_start_div  = ex_is_div;
            w_start_mult = !ex_is_div;
          end
        end
      end

      ISSUE: begin
        w_timer_clear = 1'b1;
        w_next_state  = WAIT;
      end

      WAIT: begin
        w_timer_en = 1'b1;
        // Ready is checked first so a result arriving on the last allowed
        // cycle is still delivered rather than reported as a timeout.
        if (md_resultRDY) begin
          w_next_state = DONE;
          w_wb_load    = 1'b1;
          w_wb_exc     = md_exception ? EXC_DIV0 : EXC_NONE;
          w_wb_result  = md_exception ? 32'd0 : md_result;
        end else if (w_timer_term) begin
          w_next_state = DONE;
          w_wb_load    = 1'b1;
          w_wb_exc     = EXC_TIMEOUT;
        end
      end

      DONE: begin
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand and destination latches; held until the next accepted op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_opA <= '0;
      md_opB <= '0;
      r_rd   <= '0;
    end else if (w_accept) begin
      md_opA <= ex_opA;
      md_opB <= ex_opB;
      r_rd   <= ex_rd;
    end
  end

  // Start pulses: set on the IDLE->ISSUE edge, so high only during ISSUE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
    end else begin
      md_ctrl_MULT <= w_start_mult;
      md_ctrl_DIV  <= w_start_div;
    end
  end

  // Writeback strobe and payload, loaded on entry to DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_result <= '0;
      wb_exc    <= EXC_NONE;
    end else begin
      wb_valid <= w_wb_load;
      if (w_wb_load) begin
        wb_rd     <= w_wb_rd;
        wb_result <= w_wb_result;
        wb_exc    <= w_wb_exc;
      end
    end
  end

  assign stall = (r_state != IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl: a table of single ops with
// hand-computed timing and results, plus reset, stray-ready and
// back-to-back sequences.
module tb_multdiv_issue_ctrl;

  logic        clock;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_is_div;
  logic [31:0] ex_opA;
  logic [31:0] ex_opB;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic        md_resultRDY;
  logic [31:0] md_result;
  logic        md_exception;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [1:0]  wb_exc;

  int checks = 0;
  int errors = 0;

  multdiv_issue_ctrl #(
    .REG_W   (5),
    .TIMEOUT (40)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_is_div    (ex_is_div),
    .ex_opA       (ex_opA),
    .ex_opB       (ex_opB),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .md_opA       (md_opA),
    .md_opB       (md_opB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_resultRDY (md_resultRDY),
    .md_result    (md_result),
    .md_exception (md_exception),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .wb_exc       (wb_exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    int          rdy_cyc;     // cycle the unit model raises ready (0 = never)
    logic [31:0] rdy_result;
    logic        rdy_exc;
    int          exp_pulses;
    int          exp_wb_cyc;
    logic [1:0]  exp_exc;
    logic [31:0] exp_result;
  } op_vec_t;

  op_vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"},     {31'd0, stall},        32'd0);
    check({tag, " md_opA"},    md_opA,                32'd0);
    check({tag, " md_opB"},    md_opB,                32'd0);
    check({tag, " md_ctrl"},   {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    check({tag, " wb_valid"},  {31'd0, wb_valid},     32'd0);
    check({tag, " wb_rd"},     {27'd0, wb_rd},        32'd0);
    check({tag, " wb_result"}, wb_result,             32'd0);
    check({tag, " wb_exc"},    {30'd0, wb_exc},       32'd0);
  endtask

  // Present one op for a single cycle and model the unit's ready response.
  task automatic run_op(input int idx, input op_vec_t v);
    int          pulses    = 0;
    int          pulse_cyc = -1;
    logic        pulse_div = 1'b0;
    int          wb_cnt    = 0;
    int          wb_cyc    = -1;
    logic [4:0]  s_rd      = '0;
    logic [31:0] s_result  = '0;
    logic [1:0]  s_exc     = '0;
    int          stall_bad = 0;
    logic        exp_stall;
    string       tag;
    tag = $sformatf("vec%0d", idx);

    @(posedge clock); #1;
    ex_valid     = 1'b1;
    ex_is_div    = v.is_div;
    ex_opA       = v.op_a;
    ex_opB       = v.op_b;
    ex_rd        = v.rd;
    md_resultRDY = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;

    for (int cyc = 0; cyc <= v.exp_wb_cyc + 2; cyc++) begin
      if (cyc > 0) begin
        @(posedge clock); #1;
        ex_valid     = 1'b0;
        md_resultRDY = (cyc == v.rdy_cyc);
        md_result    = (cyc == v.rdy_cyc) ? v.rdy_result : 32'd0;
        md_exception = (cyc == v.rdy_cyc) ? v.rdy_exc : 1'b0;
      end
      @(negedge clock);
      if (md_ctrl_MULT || md_ctrl_DIV) begin
        pulses = pulses + int'(md_ctrl_MULT) + int'(md_ctrl_DIV);
        if (pulse_cyc < 0) begin
          pulse_cyc = cyc;
          pulse_div = md_ctrl_DIV;
        end
      end
      if (wb_valid) begin
        wb_cnt++;
        if (wb_cyc < 0) begin
          wb_cyc   = cyc;
          s_rd     = wb_rd;
          s_result = wb_result;
          s_exc    = wb_exc;
        end
      end
      exp_stall = (cyc >= 1) && (cyc <= v.exp_wb_cyc);
      if (stall !== exp_stall) stall_bad++;
    end
    md_resultRDY = 1'b0;
    md_exception = 1'b0;

    check({tag, " start pulses"}, pulses, v.exp_pulses);
    if (v.exp_pulses > 0) begin
      check({tag, " pulse cycle"}, pulse_cyc, 32'd1);
      check({tag, " pulse is div"}, {31'd0, pulse_div}, {31'd0, v.is_div});
    end
    check({tag, " wb_valid count"}, wb_cnt, 32'd1);
    check({tag, " wb_valid cycle"}, wb_cyc, v.exp_wb_cyc);
    check({tag, " wb_rd"}, {27'd0, s_rd}, {27'd0, v.rd});
    check({tag, " wb_result"}, s_result, v.exp_result);
    check({tag, " wb_exc"}, {30'd0, s_exc}, {30'd0, v.exp_exc});
    check({tag, " stall cycles wrong"}, stall_bad, 32'd0);
    check({tag, " md_opA held"}, md_opA, v.op_a);
    check({tag, " md_opB held"}, md_opB, v.op_b);
  endtask

  initial begin
    int wb_seen;
    int stall_seen;

    //           div   opA           opB           rd     rdy  rdy_result    exc   pul wbc exc          result
    vecs[0] = '{1'b1, 32'd100,      32'd7,        5'd5,  5,   32'd14,       1'b0, 1,  6,  2'b00, 32'd14};
    vecs[1] = '{1'b1, 32'd100,      32'd0,        5'd6,  4,   32'h0000FFFF, 1'b1, 1,  5,  2'b01, 32'd0};
    vecs[2] = '{1'b1, 32'd100,      32'h00010000, 5'd7,  0,   32'd0,        1'b0, 0,  1,  2'b10, 32'd0};
    vecs[3] = '{1'b1, 32'hFFFF0000, 32'hFFFF8000, 5'd8,  3,   32'd2,        1'b0, 1,  4,  2'b00, 32'd2};
    vecs[4] = '{1'b1, 32'h00007FFF, 32'h00007FFF, 5'd9,  2,   32'd1,        1'b0, 1,  3,  2'b00, 32'd1};
    vecs[5] = '{1'b1, 32'd1,        32'h00008000, 5'd10, 0,   32'd0,        1'b0, 0,  1,  2'b10, 32'd0};
    vecs[6] = '{1'b0, 32'd6,        32'd7,        5'd11, 2,   32'd42,       1'b0, 1,  3,  2'b00, 32'd42};
    vecs[7] = '{1'b0, 32'h12345678, 32'd1,        5'd12, 41,  32'h12345678, 1'b0, 1,  42, 2'b00, 32'h12345678};
    vecs[8] = '{1'b0, 32'd3,        32'd3,        5'd13, 0,   32'd0,        1'b0, 1,  42, 2'b11, 32'd0};

    reset_n      = 1'b0;
    ex_valid     = 1'b0;
    ex_is_div    = 1'b0;
    ex_opA       = '0;
    ex_opB       = '0;
    ex_rd        = '0;
    md_resultRDY = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;

    #3;
    check_all_zero("reset");
    #9;
    reset_n = 1'b1;

    // Table of single ops; the last entry is the timeout case.
    for (int i = 0; i < 9; i++) begin
      run_op(i, vecs[i]);
    end

    // A late ready after the timeout must not produce another writeback.
    wb_seen    = 0;
    stall_seen = 0;
    @(posedge clock); #1;
    md_resultRDY = 1'b1;
    md_result    = 32'h1234;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (wb_valid) wb_seen++;
      if (stall)    stall_seen++;
    end
    md_resultRDY = 1'b0;
    md_result    = '0;
    check("late ready wb_valid", wb_seen, 32'd0);
    check("late ready stall", stall_seen, 32'd0);

    // Reset in the middle of WAIT aborts the op with no writeback.
    @(posedge clock); #1;
    ex_valid  = 1'b1;
    ex_is_div = 1'b1;
    ex_opA    = 32'd77;
    ex_opB    = 32'd7;
    ex_rd     = 5'd21;
    @(posedge clock); #1;
    ex_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre-abort stall", {31'd0, stall}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clock); #1;
    md_resultRDY = 1'b1;
    md_result    = 32'd11;
    @(posedge clock); #2;
    reset_n = 1'b1;
    wb_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (wb_valid) wb_seen++;
    end
    md_resultRDY = 1'b0;
    md_result    = '0;
    check("abort no wb_valid", wb_seen, 32'd0);
    check("abort back to idle", {31'd0, stall}, 32'd0);
    run_op(100, '{1'b1, 32'd50, 32'd5, 5'd22, 3, 32'd10, 1'b0, 1, 4, 2'b00, 32'd10});

    // Back-to-back: ex_valid held high; op2 appears while op1 is in flight.
    begin
      int          pulses  = 0;
      int          rdy_at  = -1;
      int          wb_n    = 0;
      logic        p_div[2];
      int          w_cyc[2];
      logic [4:0]  w_rd[2];
      logic [31:0] w_res[2];
      logic [31:0] model_res[2];
      model_res[0] = 32'd15;
      model_res[1] = 32'd10;
      p_div[0] = 1'b0; p_div[1] = 1'b0;
      w_cyc[0] = -1;   w_cyc[1] = -1;
      w_rd[0]  = '0;   w_rd[1]  = '0;
      w_res[0] = '0;   w_res[1] = '0;

      @(posedge clock); #1;
      ex_valid  = 1'b1;
      ex_is_div = 1'b0;
      ex_opA    = 32'd3;
      ex_opB    = 32'd5;
      ex_rd     = 5'd7;
      for (int cyc = 0; cyc < 14; cyc++) begin
        if (cyc > 0) begin
          @(posedge clock); #1;
          if (pulses >= 1) begin
            ex_is_div = 1'b1;
            ex_opA    = 32'd50;
            ex_opB    = 32'd5;
            ex_rd     = 5'd9;
          end
          if (pulses >= 2) ex_valid = 1'b0;
          md_resultRDY = (cyc == rdy_at);
          md_result    = (cyc == rdy_at && pulses >= 1) ? model_res[pulses-1] : 32'd0;
        end
        @(negedge clock);
        if (md_ctrl_MULT || md_ctrl_DIV) begin
          if (pulses < 2) p_div[pulses] = md_ctrl_DIV;
          pulses++;
          rdy_at = cyc + 2;
        end
        if (wb_valid) begin
          if (wb_n < 2) begin
            w_cyc[wb_n] = cyc;
            w_rd[wb_n]  = wb_rd;
            w_res[wb_n] = wb_result;
          end
          wb_n++;
        end
      end
      ex_valid     = 1'b0;
      md_resultRDY = 1'b0;
      check("b2b start pulses", pulses, 32'd2);
      check("b2b wb count", wb_n, 32'd2);
      check("b2b op1 is mult", {31'd0, p_div[0]}, 32'd0);
      check("b2b op2 is div", {31'd0, p_div[1]}, 32'd1);
      check("b2b op1 wb cycle", w_cyc[0], 32'd4);
      check("b2b op2 wb cycle", w_cyc[1], 32'd9);
      check("b2b op1 rd", {27'd0, w_rd[0]}, 32'd7);
      check("b2b op2 rd", {27'd0, w_rd[1]}, 32'd9);
      check("b2b op1 result", w_res[0], 32'd15);
      check("b2b op2 result", w_res[1], 32'd10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Sequencing front-end for the multiply/divide unit. It sits between the execute stage and the mult/div datapaths and accepts one mult or div operation at a time. It latches the operands, issues a one-cycle start pulse, waits for the unit's result-ready handshake and enforces a timeout. It returns the result, destination register and exception code to writeback, holding the pipeline stalled meanwhile.

## Interface
Parameters:
- REG_W, 5, destination register address width
- TIMEOUT, 40, maximum cycles in WAIT before a timeout exception

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents a mult/div op this cycle
- ex_is_div  in  1  1 = divide, 0 = multiply
- ex_opA  in  32  operand A
- ex_opB  in  32  operand B
- ex_rd  in  REG_W  destination register
- stall  out  1  hold upstream pipeline
- md_opA  out  32  latched operand A to the unit
- md_opB  out  32  latched operand B; divider consumes [15:0]
- md_ctrl_MULT  out  1  one-cycle multiply start
- md_ctrl_DIV  out  1  one-cycle divide start
- md_resultRDY  in  1  unit result valid
- md_result  in  32  unit result
- md_exception  in  1  unit exception (divide by zero)
- wb_valid  out  1  one-cycle result strobe
- wb_rd  out  REG_W  destination register
- wb_result  out  32  result (0 on any exception)
- wb_exc  out  2  00 none, 01 div-by-zero, 10 divisor out of range, 11 timeout

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Reset: state IDLE, and all outputs 0, including stall, md_*, wb_* and the timer.
- IDLE:
  - ex_valid=1 latches opA, opB, rd and is_div.
  - Divide with ex_opB[31:15] not all-equal (not a signed 16-bit value): go to DONE with wb_exc=10. No start pulse is issued.
  - Otherwise go to ISSUE.
- ISSUE: assert md_ctrl_DIV or md_ctrl_MULT for exactly one cycle, clear the timer, go to WAIT.
- WAIT: the timer increments each cycle.
  - md_resultRDY=1: capture md_result and md_exception. Go to DONE with wb_exc=01 if md_exception is set, else 00.
  - Timer == TIMEOUT-1 with no ready: go to DONE with wb_exc=11.
  - If ready and timeout occur in the same cycle, ready wins.
- DONE: wb_valid=1 for one cycle with wb_rd, wb_result and wb_exc, then go to IDLE.
- stall=1 in ISSUE, WAIT and DONE; stall=0 in IDLE.
- ex_valid outside IDLE is ignored. Upstream is stalled, so it re-presents the op later.
- md_opA and md_opB hold their latched values from acceptance until the next acceptance.
- wb_result is forced to 0 whenever wb_exc != 00.
- md_resultRDY outside WAIT is ignored.
- A reset_n assertion mid-operation aborts immediately to IDLE. No wb_valid is produced for the aborted op.

## Timing
- Cycle 0: IDLE samples ex_valid.
- Cycle 1: ISSUE, start pulse high.
- Cycle 2 onward: WAIT.
- If md_resultRDY is first seen in cycle N, wb_valid is high in cycle N+1.
- Back-to-back ops: the next ex_valid is accepted in the cycle after DONE, so minimum spacing is 4 cycles plus the unit latency.
- Range-error path: DONE in cycle 1, so wb_valid is high in cycle 1.
- Timeout path: wb_valid is high in cycle 2+TIMEOUT.
- All outputs are registered except stall, which decodes from the state register only.

## Structure
- Shared package: the state enum (IDLE=0, ISSUE=1, WAIT=2, DONE=3), the exception code constants (EXC_NONE, EXC_DIV0, EXC_RANGE, EXC_TIMEOUT), and the default TIMEOUT.
- One sub-module, multdiv_wait_timer: a clearable up-counter with a terminal-count flag at TIMEOUT-1, parameterised by TIMEOUT.

## Test plan
- Div 100 / 7: md_ctrl_DIV pulses once in cycle 1. The model raises md_resultRDY=1 with result 14 in cycle 5. Expect wb_valid in cycle 6 with wb_result=14, wb_exc=00, wb_rd equal to ex_rd, and stall high in cycles 1-6.
- Div opB=0: the model returns md_exception=1 with result 0xFFFF. Expect wb_exc=01 and wb_result=0.
- Div opB=0x00010000: expect no md_ctrl_DIV, wb_valid in cycle 1, and wb_exc=10. Also apply opB=0xFFFF8000 (-32768), which must be accepted and issued.
- Mult with the model never ready and TIMEOUT=40: expect wb_valid in cycle 42 with wb_exc=11. A later md_resultRDY must be ignored.
- Pulse reset_n low during WAIT: expect all outputs 0 asynchronously and no wb_valid. An op issued after reset completes normally.
- Two back-to-back ops, with ex_valid held high while stalled: expect exactly two start pulses and two wb_valid strobes in order, with correct rd and results.
